// File: rtl/idecoder_pkg.sv
// Shared Ch0re decode types: opcodes, instruction formats, ALU ops and operand-mux selects.
package ch0re_types;

    localparam int XLEN = 64;

    typedef enum logic [4:0] {
        OPC_LOAD     = 5'b00000,
        OPC_MISC_MEM = 5'b00011,
        OPC_OP_IMM   = 5'b00100,
        OPC_AUIPC    = 5'b00101,
        OPC_OP_IMM32 = 5'b00110,
        OPC_STORE    = 5'b01000,
        OPC_OP       = 5'b01100,
        OPC_LUI      = 5'b01101,
        OPC_OP32     = 5'b01110,
        OPC_BRANCH   = 5'b11000,
        OPC_JALR     = 5'b11001,
        OPC_JAL      = 5'b11011
    } opcode_e;

    typedef enum logic [2:0] {
        IFORMAT_R = 3'd0,
        IFORMAT_I = 3'd1,
        IFORMAT_S = 3'd2,
        IFORMAT_B = 3'd3,
        IFORMAT_U = 3'd4,
        IFORMAT_J = 3'd5
    } iformat_e;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
        ALU_MULW, ALU_DIVW, ALU_DIVUW, ALU_REMW, ALU_REMUW
    } alu_op_e;

    typedef enum logic [1:0] {
        ALU_MUX1_SEL_REG = 2'd0,
        ALU_MUX1_SEL_PC  = 2'd1,
        ALU_MUX1_SEL_IMM = 2'd2
    } alu_mux1_sel_e;

    typedef enum logic {
        ALU_MUX2_SEL_REG = 1'b0,
        ALU_MUX2_SEL_IMM = 1'b1
    } alu_mux2_sel_e;

    typedef struct packed {
        logic          illegal;
        logic [4:0]    raddr1;
        logic [4:0]    raddr2;
        logic [4:0]    waddr;
        iformat_e      fmt;
        alu_op_e       alu_op;
        logic [XLEN-1:0] imm;
        alu_mux1_sel_e mux1;
        alu_mux2_sel_e mux2;
    } dec_t;

endpackage

// File: rtl/idecoder_intf.sv
// Port bundle between the decoder and its fetch/execute neighbours.
interface idecoder_intf;
    logic                               i_clk;
    logic                               i_rst;
    logic                               i_stall;
    logic [31:0]                        i_instr;
    logic                               o_illegal_instr;
    logic [4:0]                         o_rf_raddr1;
    logic [4:0]                         o_rf_raddr2;
    logic [4:0]                         o_rf_waddr;
    ch0re_types::iformat_e              o_instr_format;
    ch0re_types::alu_op_e               o_alu_op;
    logic [ch0re_types::XLEN-1:0]       o_imm;
    ch0re_types::alu_mux1_sel_e         o_alu_mux1_sel;
    ch0re_types::alu_mux2_sel_e         o_alu_mux2_sel;

    modport dut (
        input  i_clk, i_rst, i_stall, i_instr,
        output o_illegal_instr, o_rf_raddr1, o_rf_raddr2, o_rf_waddr,
               o_instr_format, o_alu_op, o_imm, o_alu_mux1_sel, o_alu_mux2_sel
    );
endinterface

// File: rtl/idecoder_imm_gen.sv
// Sign-extended immediate assembly for each RV64I instruction format.
module idec_imm_gen
    import ch0re_types::*;
(
    input  logic [31:7]     i_instr,
    input  iformat_e        i_format,
    output logic [XLEN-1:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_format)
            IFORMAT_I: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            IFORMAT_S: o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IFORMAT_B: o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            IFORMAT_U: o_imm = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
            IFORMAT_J: o_imm = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default:   o_imm = '0;
        endcase
    end

endmodule

// File: rtl/idecoder.sv
// RV64I single-stage decoder with registered outputs and stall hold.
// Optional M-extension decode is enabled by defining IDEC_RV64M_EN.
module idecoder
    import ch0re_types::*;
(
    idecoder_intf.dut bus
);

    opcode_e         opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd, rs1, rs2;
    logic            illegal;
    dec_t            dec_c, dec_d, dec_q;
    logic [XLEN-1:0] imm_w;

    assign opcode = opcode_e'(bus.i_instr[6:2]);
    assign rd     = bus.i_instr[11:7];
    assign f3     = bus.i_instr[14:12];
    assign rs1    = bus.i_instr[19:15];
    assign rs2    = bus.i_instr[24:20];
    assign f7     = bus.i_instr[31:25];

    always_comb begin
        dec_c   = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP32: begin
                dec_c.fmt    = IFORMAT_R;
                dec_c.raddr1 = rs1;
                dec_c.raddr2 = rs2;
                dec_c.waddr  = rd;
                case ({opcode == OPC_OP32, f7, f3})
                    {1'b0, 7'h00, 3'd0}: dec_c.alu_op = ALU_ADD;
                    {1'b0, 7'h00, 3'd1}: dec_c.alu_op = ALU_SLL;
                    {1'b0, 7'h00, 3'd2}: dec_c.alu_op = ALU_SLT;
                    {1'b0, 7'h00, 3'd3}: dec_c.alu_op = ALU_SLTU;
                    {1'b0, 7'h00, 3'd4}: dec_c.alu_op = ALU_XOR;
                    {1'b0, 7'h00, 3'd5}: dec_c.alu_op = ALU_SRL;
                    {1'b0, 7'h00, 3'd6}: dec_c.alu_op = ALU_OR;
                    {1'b0, 7'h00, 3'd7}: dec_c.alu_op = ALU_AND;
                    {1'b0, 7'h20, 3'd0}: dec_c.alu_op = ALU_SUB;
                    {1'b0, 7'h20, 3'd5}: dec_c.alu_op = ALU_SRA;
                    {1'b1, 7'h00, 3'd0}: dec_c.alu_op = ALU_ADDW;
                    {1'b1, 7'h00, 3'd1}: dec_c.alu_op = ALU_SLLW;
                    {1'b1, 7'h00, 3'd5}: dec_c.alu_op = ALU_SRLW;
                    {1'b1, 7'h20, 3'd0}: dec_c.alu_op = ALU_SUBW;
                    {1'b1, 7'h20, 3'd5}: dec_c.alu_op = ALU_SRAW;
`ifdef IDEC_RV64M_EN
                    {1'b0, 7'h01, 3'd0}: dec_c.alu_op = ALU_MUL;
                    {1'b0, 7'h01, 3'd1}: dec_c.alu_op = ALU_MULH;
                    {1'b0, 7'h01, 3'd2}: dec_c.alu_op = ALU_MULHSU;
                    {1'b0, 7'h01, 3'd3}: dec_c.alu_op = ALU_MULHU;
                    {1'b0, 7'h01, 3'd4}: dec_c.alu_op = ALU_DIV;
                    {1'b0, 7'h01, 3'd5}: dec_c.alu_op = ALU_DIVU;
                    {1'b0, 7'h01, 3'd6}: dec_c.alu_op = ALU_REM;
                    {1'b0, 7'h01, 3'd7}: dec_c.alu_op = ALU_REMU;
                    {1'b1, 7'h01, 3'd0}: dec_c.alu_op = ALU_MULW;
                    {1'b1, 7'h01, 3'd4}: dec_c.alu_op = ALU_DIVW;
                    {1'b1, 7'h01, 3'd5}: dec_c.alu_op = ALU_DIVUW;
                    {1'b1, 7'h01, 3'd6}: dec_c.alu_op = ALU_REMW;
                    {1'b1, 7'h01, 3'd7}: dec_c.alu_op = ALU_REMUW;
`endif
                    default:             illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM, OPC_OP_IMM32, OPC_LOAD, OPC_JALR: begin
                dec_c.fmt    = IFORMAT_I;
                dec_c.raddr1 = rs1;
                dec_c.waddr  = rd;
                dec_c.mux2   = ALU_MUX2_SEL_IMM;
                if (opcode == OPC_OP_IMM) begin
                    case (f3)
                        3'd0: dec_c.alu_op = ALU_ADD;
                        3'd1: if (f7[6:1] == 6'h00) dec_c.alu_op = ALU_SLL; else illegal = 1'b1;
                        3'd2: dec_c.alu_op = ALU_SLT;
                        3'd3: dec_c.alu_op = ALU_SLTU;
                        3'd4: dec_c.alu_op = ALU_XOR;
                        3'd5: begin
                            if (f7[6:1] == 6'h00)      dec_c.alu_op = ALU_SRL;
                            else if (f7[6:1] == 6'h10) dec_c.alu_op = ALU_SRA;
                            else                       illegal = 1'b1;
                        end
                        3'd6: dec_c.alu_op = ALU_OR;
                        default: dec_c.alu_op = ALU_AND;
                    endcase
                end else if (opcode == OPC_OP_IMM32) begin
                    case (f3)
                        3'd0: dec_c.alu_op = ALU_ADDW;
                        3'd1: if (f7 == 7'h00) dec_c.alu_op = ALU_SLLW; else illegal = 1'b1;
                        3'd5: begin
                            if (f7 == 7'h00)      dec_c.alu_op = ALU_SRLW;
                            else if (f7 == 7'h20) dec_c.alu_op = ALU_SRAW;
                            else                  illegal = 1'b1;
                        end
                        default: illegal = 1'b1;
                    endcase
                end else if (opcode == OPC_LOAD) begin
                    illegal = (f3 == 3'd7);
                end else begin
                    illegal = (f3 != 3'd0);
                end
            end
            OPC_STORE: begin
                dec_c.fmt    = IFORMAT_S;
                dec_c.raddr1 = rs1;
                dec_c.raddr2 = rs2;
                dec_c.mux2   = ALU_MUX2_SEL_IMM;
                illegal      = f3[2];
            end
            OPC_BRANCH: begin
                dec_c.fmt    = IFORMAT_B;
                dec_c.raddr1 = rs1;
                dec_c.raddr2 = rs2;
                case (f3[2:1])
                    2'b00:   dec_c.alu_op = ALU_SUB;
                    2'b10:   dec_c.alu_op = ALU_SLT;
                    2'b11:   dec_c.alu_op = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec_c.fmt   = IFORMAT_J;
                dec_c.waddr = rd;
                dec_c.mux1  = ALU_MUX1_SEL_PC;
                dec_c.mux2  = ALU_MUX2_SEL_IMM;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_c.fmt   = IFORMAT_U;
                dec_c.waddr = rd;
                dec_c.mux1  = (opcode == OPC_AUIPC) ? ALU_MUX1_SEL_PC : ALU_MUX1_SEL_IMM;
                dec_c.mux2  = ALU_MUX2_SEL_IMM;
            end
            default: illegal = 1'b1;
        endcase

        if (bus.i_instr[1:0] != 2'b11) illegal = 1'b1;

        // Illegal words keep their nominal-format routing but must not write or compute.
        dec_c.illegal = illegal;
        if (illegal) begin
            dec_c.waddr  = '0;
            dec_c.alu_op = ALU_ADD;
        end
    end

    idec_imm_gen u_imm_gen (
        .i_instr  (bus.i_instr[31:7]),
        .i_format (dec_c.fmt),
        .o_imm    (imm_w)
    );

    always_comb begin
        dec_d     = dec_c;
        dec_d.imm = dec_c.illegal ? '0 : imm_w;
    end

    always_ff @(posedge bus.i_clk) begin
        if (bus.i_rst) begin
            dec_q <= '0;
        end else if (!bus.i_stall) begin
            dec_q <= dec_d;
        end
    end

    assign bus.o_illegal_instr = dec_q.illegal;
    assign bus.o_rf_raddr1     = dec_q.raddr1;
    assign bus.o_rf_raddr2     = dec_q.raddr2;
    assign bus.o_rf_waddr      = dec_q.waddr;
    assign bus.o_instr_format  = dec_q.fmt;
    assign bus.o_alu_op        = dec_q.alu_op;
    assign bus.o_imm           = dec_q.imm;
    assign bus.o_alu_mux1_sel  = dec_q.mux1;
    assign bus.o_alu_mux2_sel  = dec_q.mux2;

endmodule

// File: tb/tb_idecoder.sv
// Directed-vector bench for idecoder: decode table, latency, stall hold and reset priority.
module tb_idecoder;
    import ch0re_types::*;

    typedef struct packed {
        logic        ill;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  wa;
        logic [2:0]  fmt;
        logic [4:0]  alu;
        logic [63:0] imm;
        logic [1:0]  m1;
        logic        m2;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    idecoder_intf intf ();
    assign intf.i_clk = clk;

    idecoder u_dut (.bus(intf));

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    localparam exp_t EXP_ZERO = '0;
    localparam exp_t EXP_ADDI = '{1'b0, 5'd0, 5'd0, 5'd1, IFORMAT_I, ALU_ADD, 64'd3,
                                  ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM};

    function automatic exp_t got();
        return '{intf.o_illegal_instr, intf.o_rf_raddr1, intf.o_rf_raddr2, intf.o_rf_waddr,
                 intf.o_instr_format, intf.o_alu_op, intf.o_imm,
                 intf.o_alu_mux1_sel, intf.o_alu_mux2_sel};
    endfunction

    task automatic add(input logic [31:0] instr, input logic ill, input logic [4:0] ra1,
                       input logic [4:0] ra2, input logic [4:0] wa, input logic [2:0] fmt,
                       input logic [4:0] alu, input logic [63:0] imm, input logic [1:0] m1,
                       input logic m2);
        tbl.push_back('{instr, '{ill, ra1, ra2, wa, fmt, alu, imm, m1, m2}});
    endtask

    task automatic drive(input logic [31:0] instr);
        @(negedge clk);
        intf.i_instr = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t g;
        intf.i_rst   = 1'b1;
        intf.i_stall = 1'b0;
        drive(32'h00300093);
        drive(32'h00300093);
        g = got();
        checks++;
        if (g !== EXP_ZERO) begin
            errors++;
            $display("FAIL reset: got %h required %h", g, EXP_ZERO);
        end
        @(negedge clk);
        intf.i_rst = 1'b0;
    endtask

    task automatic test_decode();
        exp_t g;
        add(32'h00300093, 0, 0, 0, 1, IFORMAT_I, ALU_ADD, 64'd3, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM);
        add(32'h03286F83, 0, 16, 0, 31, IFORMAT_I, ALU_ADD, 64'h32, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM);
        add(32'h40518133, 0, 3, 5, 2, IFORMAT_R, ALU_SUB, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_REG);
        add(32'h00007003, 1, 0, 0, 0, IFORMAT_I, ALU_ADD, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM);
        add(32'h123452B7, 0, 0, 0, 5, IFORMAT_U, ALU_ADD, 64'h12345000, ALU_MUX1_SEL_IMM, ALU_MUX2_SEL_IMM);
        add(32'h12345297, 0, 0, 0, 5, IFORMAT_U, ALU_ADD, 64'h12345000, ALU_MUX1_SEL_PC, ALU_MUX2_SEL_IMM);
        add(32'hFFF08093, 0, 1, 0, 1, IFORMAT_I, ALU_ADD, '1, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM);
        add(32'hFE208EE3, 0, 1, 2, 0, IFORMAT_B, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFC, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_REG);
        add(32'hFE20CEE3, 0, 1, 2, 0, IFORMAT_B, ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFC, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_REG);
        add(32'hFE20EEE3, 0, 1, 2, 0, IFORMAT_B, ALU_SLTU, 64'hFFFF_FFFF_FFFF_FFFC, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_REG);
        add(32'hFE20AEE3, 1, 1, 2, 0, IFORMAT_B, ALU_ADD, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_REG);
        add(32'h008000EF, 0, 0, 0, 1, IFORMAT_J, ALU_ADD, 64'd8, ALU_MUX1_SEL_PC, ALU_MUX2_SEL_IMM);
        add(32'h0020B423, 0, 1, 2, 0, IFORMAT_S, ALU_ADD, 64'd8, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM);
        add(32'h0020C423, 1, 1, 2, 0, IFORMAT_S, ALU_ADD, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM);
        add(32'h4030D093, 0, 1, 0, 1, IFORMAT_I, ALU_SRA, 64'h403, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM);
        add(32'h4030D09B, 0, 1, 0, 1, IFORMAT_I, ALU_SRAW, 64'h403, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM);
        add(32'h2030D09B, 1, 1, 0, 0, IFORMAT_I, ALU_ADD, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM);
        add(32'h002081BB, 0, 1, 2, 3, IFORMAT_R, ALU_ADDW, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_REG);
        add(32'h00300090, 1, 0, 0, 0, IFORMAT_I, ALU_ADD, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM);
        add(32'h0000007F, 1, 0, 0, 0, IFORMAT_R, ALU_ADD, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_REG);
        add(32'h000110E7, 1, 2, 0, 0, IFORMAT_I, ALU_ADD, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_IMM);
        foreach (tbl[i]) begin
            drive(tbl[i].instr);
            g = got();
            checks++;
            if (g !== tbl[i].e) begin
                errors++;
                $display("FAIL decode[%0d] instr=%h: got %h required %h", i, tbl[i].instr, g, tbl[i].e);
            end
        end
    endtask

    task automatic test_rv64m();
        exp_t g, e_mul, e_div;
`ifdef IDEC_RV64M_EN
        e_mul = '{1'b0, 5'd2, 5'd3, 5'd1, IFORMAT_R, ALU_MUL, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_REG};
        e_div = '{1'b0, 5'd2, 5'd3, 5'd1, IFORMAT_R, ALU_DIV, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_REG};
`else
        e_mul = '{1'b1, 5'd2, 5'd3, 5'd0, IFORMAT_R, ALU_ADD, 64'd0, ALU_MUX1_SEL_REG, ALU_MUX2_SEL_REG};
        e_div = e_mul;
`endif
        drive(32'h023100B3);
        g = got();
        checks++;
        if (g !== e_mul) begin
            errors++;
            $display("FAIL mul: got %h required %h", g, e_mul);
        end
        drive(32'h023140B3);
        g = got();
        checks++;
        if (g !== e_div) begin
            errors++;
            $display("FAIL div: got %h required %h", g, e_div);
        end
    endtask

    task automatic test_latency();
        exp_t g;
        drive(32'h00300093);
        @(negedge clk);
        intf.i_instr = 32'h40518133;
        #1;
        g = got();
        checks++;
        if (g !== EXP_ADDI) begin
            errors++;
            $display("FAIL latency_pre_edge: got %h required %h", g, EXP_ADDI);
        end
        @(posedge clk);
        #1;
        checks++;
        if (intf.o_alu_op !== ALU_SUB || intf.o_rf_waddr !== 5'd2) begin
            errors++;
            $display("FAIL latency_post_edge: got alu=%0d waddr=%0d required alu=%0d waddr=2",
                     intf.o_alu_op, intf.o_rf_waddr, ALU_SUB);
        end
    endtask

    task automatic test_stall();
        exp_t g;
        drive(32'h00300093);
        @(negedge clk);
        intf.i_stall = 1'b1;
        intf.i_instr = 32'h40518133;
        repeat (2) @(posedge clk);
        #1;
        g = got();
        checks++;
        if (g !== EXP_ADDI) begin
            errors++;
            $display("FAIL stall_hold: got %h required %h", g, EXP_ADDI);
        end
    endtask

    task automatic test_reset_over_stall();
        exp_t g;
        @(negedge clk);
        intf.i_stall = 1'b1;
        intf.i_rst   = 1'b1;
        @(posedge clk);
        #1;
        g = got();
        checks++;
        if (g !== EXP_ZERO) begin
            errors++;
            $display("FAIL reset_over_stall: got %h required %h", g, EXP_ZERO);
        end
        @(negedge clk);
        intf.i_rst   = 1'b0;
        intf.i_stall = 1'b0;
    endtask

    initial begin
        intf.i_rst   = 1'b1;
        intf.i_stall = 1'b0;
        intf.i_instr = 32'h0;
        test_reset();
        test_decode();
        test_rv64m();
        test_latency();
        test_stall();
        test_reset_over_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idecoder.md
Name: idecoder

Overview:
- Single-stage RV64I instruction decoder in the Ch0re pipeline, between fetch and execute.
- Takes one 32-bit instruction word and produces:
  - register-file read/write addresses
  - instruction format
  - ALU operation and operand-mux selects
  - sign-extended 64-bit immediate
  - an illegal-instruction flag
- All outputs are registered, with one cycle of latency. The ports are bundled in the SystemVerilog interface idecoder_intf; the module takes that interface as its only port.

Parameters:
- XLEN, 64, width of o_imm.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_stall  in  1  when 1, all outputs hold their current value.
- i_instr  in  32  instruction word.
- o_illegal_instr  out  1  instruction is not a legal RV64I encoding.
- o_rf_raddr1  out  5  rs1 address.
- o_rf_raddr2  out  5  rs2 address.
- o_rf_waddr  out  5  rd address.
- o_instr_format  out  3  iformat_e: IFORMAT_R, IFORMAT_I, IFORMAT_S, IFORMAT_B, IFORMAT_U, IFORMAT_J.
- o_alu_op  out  5  alu_op_e.
- o_imm  out  XLEN  sign-extended immediate.
- o_alu_mux1_sel  out  2  ALU_MUX1_SEL_REG, ALU_MUX1_SEL_PC, ALU_MUX1_SEL_IMM (the IMM select drives constant zero).
- o_alu_mux2_sel  out  1  ALU_MUX2_SEL_REG, ALU_MUX2_SEL_IMM.

Behaviour:
- Timing:
  - Combinational decode of i_instr is registered on the rising edge of i_clk when i_rst=0 and i_stall=0.
  - Outputs reflect the instruction sampled at the previous edge.
  - i_rst has priority over i_stall.
- Reset values: all outputs 0, i.e. o_illegal_instr=0, format IFORMAT_R (encoding 0), ALU_ADD, MUX1_REG, MUX2_REG, o_imm=0, all addresses 0.
- Field extraction: opcode is i_instr[6:2] with i_instr[1:0] required to be 2'b11; rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- R-type (OP, OP32): format R; raddr1=rs1, raddr2=rs2, waddr=rd; mux1 REG, mux2 REG; imm 0.
  - OP, funct7=0x00 with funct3 0..7: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - OP, funct7=0x20 with funct3 0: SUB; with funct3 5: SRA.
  - OP32, funct7=0x00 with funct3 0/1/5: ADDW, SLLW, SRLW.
  - OP32, funct7=0x20 with funct3 0: SUBW; with funct3 5: SRAW.
  - Any other combination is illegal.
- I-type (OP_IMM, OP_IMM32, LOAD, JALR): format I; raddr1=rs1, raddr2=0, waddr=rd; mux1 REG, mux2 IMM; imm = sext(instr[31:20]).
  - OP_IMM shifts (funct3 1/5): instr[31:26] must be 0x00 (SLLI/SRLI) or 0x10 (SRAI, funct3 5 only).
  - OP_IMM32: funct3 0 is ADDIW. Funct3 1/5 need instr[31:25] = 0x00 (SLLIW/SRLIW) or 0x20 (SRAIW, funct3 5 only). Other funct3 values are illegal.
  - LOAD: funct3 7 is illegal; alu ADD.
  - JALR: funct3 must be 0; alu ADD.
- S-type (STORE): format S; raddr1=rs1, raddr2=rs2, waddr=0; mux1 REG, mux2 IMM; imm = sext({[31:25],[11:7]}); alu ADD; funct3 greater than 3 is illegal.
- B-type (BRANCH): format B; raddr1=rs1, raddr2=rs2, waddr=0; mux1 REG, mux2 REG; imm = sext({[31],[7],[30:25],[11:8],0}).
  - alu op: SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
  - funct3 2/3 is illegal.
- JAL: format J; waddr=rd, raddr1=raddr2=0; mux1 PC, mux2 IMM; imm = sext({[31],[19:12],[20],[30:21],0}); alu ADD.
- LUI: format U; waddr=rd; mux1 IMM (zero), mux2 IMM; imm = sext({[31:12],12'b0}); alu ADD.
- AUIPC: same as LUI except mux1 PC.
- Any other opcode, or i_instr[1:0]≠2'b11, is illegal.
- Illegal instructions:
  - o_illegal_instr=1, o_rf_waddr=0, o_alu_op=ALU_ADD, o_imm=0.
  - The remaining outputs take the decode of the opcode's nominal format.

Optional Feature:
- Macro IDEC_RV64M_EN.
- Defined: OP with funct7=0x01 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU by funct3. OP32 with funct7=0x01 decodes MULW (funct3 0), DIVW (4), DIVUW (5), REMW (6), REMUW (7).
- Not defined: funct7=0x01 is illegal.
- alu_op_e is 5 bits in both builds.

Decomposition:
- Package ch0re_types holds opcode_e, iformat_e, alu_op_e, alu_mux1_sel_e and alu_mux2_sel_e.
- Interface idecoder_intf carries the ports.
- Optional combinational sub-module idec_imm_gen: (instr, format) → o_imm.

Test Plan:
- addi x1,x0,3 (0x00300093) → next cycle: illegal 0, raddr1 0, waddr 1, IFORMAT_I, MUX1_REG, MUX2_IMM, imm 3, ALU_ADD.
- lwu x31,0x32(x16) (0x03286F83) → raddr1 16, waddr 31, IFORMAT_I, MUX2_IMM, imm 0x32.
- sub x2,x3,x5 (0x40518133) → raddr1 3, raddr2 5, waddr 2, IFORMAT_R, MUX1/MUX2 REG, ALU_SUB.
- Load with funct3 7 (0x00007003) → illegal 1, waddr 0.
- lui x5,0x12345 (0x123452B7) → IFORMAT_U, waddr 5, MUX1_IMM, MUX2_IMM, imm 0x12345000. auipc → MUX1_PC.
- Control interaction:
  - i_stall=1 while i_instr changes → outputs unchanged.
  - i_rst=1 with i_stall=1 → all outputs 0 next cycle.
